sparse_csr_pp_buf: RTL
======================

SPARSE_CSR_PP_BUF -- requirements
Module: sparse_csr_pp_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width of stored CSR words.
REQ-002 SHALL have parameter DEPTH, default 35, maximum words per bank (data+indices+indptr of one tile).
REQ-003 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports s_valid input 1, s_ready output 1, s_data input DATA_W, s_last input 1: DMA write stream, s_last marks final word of a tile.
REQ-006 SHALL have ports m_valid output 1, m_ready input 1, m_data output DATA_W, m_last output 1: read stream to vector engine.
REQ-007 SHALL have port bank_full  output  2  per-bank committed flag.
REQ-008 SHALL have port wr_count  output  $clog2(DEPTH+1)  words written into current write bank.

Function
REQ-009 SHALL contain two banks of DEPTH x DATA_W words, ping-pong: DMA fills one while the other drains.
REQ-010 Each bank SHALL run FSM EMPTY -> FILLING (first accepted write) -> FULL (commit) -> DRAINING (first accepted read) -> EMPTY (last word accepted).
REQ-011 Write accepted when s_valid && s_ready; word stored at index wr_count of wr_bank, wr_count increments.
REQ-012 s_ready SHALL be high iff wr_bank state is EMPTY or FILLING.
REQ-013 Bank SHALL commit on accepted write with s_last=1 or with wr_count==DEPTH-1; committed length recorded; wr_bank toggles and wr_count clears in the same edge.
REQ-014 m_valid SHALL be high iff rd_bank state is FULL or DRAINING; first asserted the cycle after the commit edge (1-cycle commit latency).
REQ-015 m_data SHALL equal word rd_ptr of rd_bank while m_valid, else 0; m_last high iff rd_ptr == length-1.
REQ-016 Read accepted when m_valid && m_ready; rd_ptr increments; on accepted m_last bank returns to EMPTY, rd_ptr clears, rd_bank toggles.
REQ-017 Commit of one bank and free of the other in the same cycle SHALL both take effect.
REQ-018 Tile of length 1 (s_last on first word) SHALL be legal; m_last asserted with first m_valid.
REQ-019 s_data/m_ready SHALL be ignored when s_valid/m_valid low; no stall beyond handshakes (1 word/cycle each side).

Reset
REQ-020 On rstn low: both banks EMPTY, wr_bank=rd_bank=0, wr_count=rd_ptr=0, s_ready=1 after release, m_valid=0, m_data=0, m_last=0, bank_full=0.
REQ-021 Reset mid-tile SHALL discard partial and committed tiles; memory contents need not be cleared.

Configuration
REQ-022 With SPARSE_BUF_ERR_EN defined, SHALL add output err  2: bit0 sticky on s_valid while s_ready low for more than 1024 consecutive cycles (write stall timeout), bit1 sticky on m_ready high while m_valid low after any tile completed (underrun); cleared only by reset.
REQ-023 Without SPARSE_BUF_ERR_EN, port err and its logic SHALL be absent; behaviour otherwise identical.

Structure
REQ-024 Package sparse_buf_pkg SHALL hold bank_state_t enum (EMPTY, FILLING, FULL, DRAINING), DEFAULT_DATA_W=32, DEFAULT_DEPTH=35.
REQ-025 Sub-module sparse_bank (storage, length, state FSM for one bank) SHALL be instantiated twice; top holds wr_bank/rd_bank select and counters.

Verification
REQ-026 Write 35 words 0x0..0x22 no s_last, m_ready=1 -> commit at word 35, m_valid next cycle, reads 0x0..0x22, m_last on 0x22.
REQ-027 Write 5 words with s_last on 5th -> m_last on 5th read; bank EMPTY after it; wr_count=0 after commit.
REQ-028 Fill bank0 and bank1, m_ready=0 -> s_ready=0, bank_full=2'b11; raise m_ready -> s_ready=1 the cycle after bank0's m_last accepted.
REQ-029 bank1 s_last accepted same cycle as bank0 m_last accepted -> both take effect, m_valid stays high into bank1 data.
REQ-030 Assert rstn low after 10 words of a tile -> all outputs at reset values, new 3-word tile reads back correctly.
REQ-031 With SPARSE_BUF_ERR_EN: m_ready high with buffer empty after one tile -> err[1]=1, persists until reset.

Source files
------------

// File: rtl/sparse_buf_pkg.sv
// Shared types and defaults for the ping-pong CSR tile buffer.
package sparse_buf_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_DEPTH  = 35;

    // Write-side stall length (in cycles) tolerated before flagging a timeout.
    localparam int unsigned STALL_LIMIT = 1024;

    // A bank holds a committed tile until its last word has been read.
    function automatic logic is_committed(input logic [1:0] st);
        return (st == FULL) || (st == DRAINING);
    endfunction

endpackage

// File: rtl/sparse_bank.sv
// One buffer bank: word storage, committed tile length and the bank lifecycle FSM.
module sparse_bank
    import sparse_buf_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned LW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              commit,
    input  logic [LW-1:0]     commit_len,
    input  logic              rd_en,
    input  logic              rd_last,
    input  logic [AW-1:0]     rd_idx,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        state,
    output logic [LW-1:0]     len
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    bank_state_t       state_q, state_d;
    logic [LW-1:0]     len_q, len_d;

    // Storage is not reset; stale words are never exposed because reads are gated by state.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_idx];

    // Bank lifecycle: a length-1 tile jumps EMPTY->FULL, and FULL->EMPTY on a single read.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        unique case (state_q)
            EMPTY: begin
                if (wr_en) begin
                    state_d = commit ? FULL : FILLING;
                end
            end
            FILLING: begin
                if (wr_en && commit) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (rd_en) begin
                    state_d = rd_last ? EMPTY : DRAINING;
                end
            end
            DRAINING: begin
                if (rd_en && rd_last) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (wr_en && commit) begin
            len_d = commit_len;
        end
    end

    // State and length registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= EMPTY;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
        end
    end

    assign state = state_q;
    assign len   = len_q;

endmodule

// File: rtl/sparse_csr_pp_buf.sv
// Ping-pong buffer for CSR tiles between a DMA write stream and the vector engine.
// Optional error reporting (stall timeout, read underrun) is built with SPARSE_BUF_ERR_EN.
module sparse_csr_pp_buf
    import sparse_buf_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned DEPTH  = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [DATA_W-1:0]          s_data,
    input  logic                       s_last,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_W-1:0]          m_data,
    output logic                       m_last,
    output logic [1:0]                 bank_full,
    output logic [$clog2(DEPTH+1)-1:0] wr_count
`ifdef SPARSE_BUF_ERR_EN
    ,
    output logic [1:0]                 err
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [LW-1:0]     wr_count_q, wr_count_d;
    logic [LW-1:0]     rd_ptr_q, rd_ptr_d;

    logic [1:0]        bank_st [2];
    logic [LW-1:0]     bank_len [2];
    logic [DATA_W-1:0] bank_rdata [2];
    logic [1:0]        bank_wr_en;
    logic [1:0]        bank_rd_en;

    bank_state_t       wr_state, rd_state;
    logic              wr_fire, rd_fire, commit, rd_last;
    logic [LW-1:0]     rd_len;

    assign wr_state = bank_state_t'(bank_st[wr_bank_q]);
    assign rd_state = bank_state_t'(bank_st[rd_bank_q]);
    assign rd_len   = bank_len[rd_bank_q];

    // Handshakes, commit detection and per-bank strobes.
    always_comb begin
        s_ready    = (wr_state == EMPTY) || (wr_state == FILLING);
        m_valid    = (rd_state == FULL) || (rd_state == DRAINING);
        wr_fire    = s_valid && s_ready;
        rd_fire    = m_valid && m_ready;
        commit     = wr_fire && (s_last || (wr_count_q == LW'(DEPTH - 1)));
        rd_last    = m_valid && (rd_ptr_q == rd_len - LW'(1));
        m_last     = rd_last;
        m_data     = m_valid ? bank_rdata[rd_bank_q] : '0;
        bank_wr_en = '0;
        bank_rd_en = '0;
        bank_wr_en[wr_bank_q] = wr_fire;
        bank_rd_en[rd_bank_q] = rd_fire;
        bank_full  = {is_committed(bank_st[1]), is_committed(bank_st[0])};
    end

    // Write and read pointers; commit and free are independent so both may land on one edge.
    always_comb begin
        wr_count_d = wr_count_q;
        wr_bank_d  = wr_bank_q;
        rd_ptr_d   = rd_ptr_q;
        rd_bank_d  = rd_bank_q;
        if (wr_fire) begin
            if (commit) begin
                wr_count_d = '0;
                wr_bank_d  = ~wr_bank_q;
            end else begin
                wr_count_d = wr_count_q + LW'(1);
            end
        end
        if (rd_fire) begin
            if (rd_last) begin
                rd_ptr_d  = '0;
                rd_bank_d = ~rd_bank_q;
            end else begin
                rd_ptr_d = rd_ptr_q + LW'(1);
            end
        end
    end

    // Bank select and pointer registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_count_q <= '0;
            rd_ptr_q   <= '0;
        end else begin
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_count_q <= wr_count_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    assign wr_count = wr_count_q;

    sparse_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_bank0 (
        .clk        (clk),
        .rstn       (rstn),
        .wr_en      (bank_wr_en[0]),
        .wr_idx     (wr_count_q[AW-1:0]),
        .wr_data    (s_data),
        .commit     (commit),
        .commit_len (wr_count_q + LW'(1)),
        .rd_en      (bank_rd_en[0]),
        .rd_last    (rd_last),
        .rd_idx     (rd_ptr_q[AW-1:0]),
        .rd_data    (bank_rdata[0]),
        .state      (bank_st[0]),
        .len        (bank_len[0])
    );

    sparse_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_bank1 (
        .clk        (clk),
        .rstn       (rstn),
        .wr_en      (bank_wr_en[1]),
        .wr_idx     (wr_count_q[AW-1:0]),
        .wr_data    (s_data),
        .commit     (commit),
        .commit_len (wr_count_q + LW'(1)),
        .rd_en      (bank_rd_en[1]),
        .rd_last    (rd_last),
        .rd_idx     (rd_ptr_q[AW-1:0]),
        .rd_data    (bank_rdata[1]),
        .state      (bank_st[1]),
        .len        (bank_len[1])
    );

`ifdef SPARSE_BUF_ERR_EN
    logic [10:0] stall_cnt_q, stall_cnt_d;
    logic        tile_done_q, tile_done_d;
    logic [1:0]  err_q, err_d;
    logic        stalled;

    // Sticky error flags: bit0 after a write stall longer than STALL_LIMIT cycles,
    // bit1 when the consumer asks for data with nothing buffered after a tile has completed.
    always_comb begin
        stalled     = s_valid && !s_ready;
        stall_cnt_d = '0;
        if (stalled) begin
            stall_cnt_d = (stall_cnt_q == 11'(STALL_LIMIT)) ? stall_cnt_q
                                                            : stall_cnt_q + 11'd1;
        end
        tile_done_d = tile_done_q | (rd_fire && rd_last);
        err_d       = err_q;
        err_d[0]    = err_q[0] | (stalled && (stall_cnt_q == 11'(STALL_LIMIT)));
        err_d[1]    = err_q[1] | (m_ready && !m_valid && tile_done_q);
    end

    // Error tracking registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_q <= '0;
            tile_done_q <= 1'b0;
            err_q       <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            tile_done_q <= tile_done_d;
            err_q       <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule
